lsu_dmem_bridge: RTL and testbench

- Load/store unit between the core's MEM stage and the data-memory bus, on the downstream side of the core's DMEM port (daddr/ddata_w/d_w/d_r/ddata_r).
- Turns a single-cycle core access into a req/gnt/rvalid bus transaction.
- Generates byte lanes for SB/SH/SW and sign- or zero-extends LB/LH/LBU/LHU/LW results.
- Holds the core on `core_stall` until the access completes, and bounds every bus wait with a timeout counter.

---
 rtl/lsu_dmem_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_dmem_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_bridge.sv
// lsu_dmem_bridge: load/store unit between the core MEM-stage DMEM port and a
// req/gnt/rvalid data bus. It holds the core on core_stall for the whole
// access, builds byte lanes for stores, sign/zero-extends loads and bounds
// every bus wait with a timeout counter.
// Ports:
//   CLK, RESET (sync, active-high)
//   core_req_r/core_req_w/core_addr/core_wdata/core_funct3 : core request
//   core_stall, core_rdata, core_rvalid : core response
//   misalign_exc, bus_timeout : one-cycle status pulses
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata, bus_gnt/bus_rvalid/bus_rdata
// Optional macro MISALIGN_TRAP_EN: misaligned halfword/word accesses skip the
// bus, pulse misalign_exc and return 0 (reads) or are dropped (writes).
module lsu_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESP_ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        core_req_r,
    input  logic        core_req_w,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    output logic        misalign_exc,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] tmo_cnt;
    logic [1:0]  addr_lo;
    logic [2:0]  f3;
    logic        is_wr;

    logic        start;
    logic        wr_sel;
    logic        mis;
    logic        tmo_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign start  = core_req_r | core_req_w;
    // A simultaneous load and store request is served as the store.
    assign wr_sel = core_req_w;

    always_comb begin
        unique case (state)
            IDLE:        core_stall = start;
            REQ, WAIT_R: core_stall = 1'b1;
            default:     core_stall = 1'b0;
        endcase
    end

    // Store lanes; undefined sizes fall back to a full word, reads use all lanes.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = 32'h0;
        if (wr_sel) begin
            wdata_nxt = core_wdata;
            case (core_funct3)
                3'b000, 3'b100: begin
                    be_nxt    = 4'b0001 << core_addr[1:0];
                    wdata_nxt = {4{core_wdata[7:0]}};
                end
                3'b001, 3'b101: begin
                    be_nxt    = core_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{core_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (core_funct3)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = core_addr[0];
            default:        mis = |core_addr[1:0];
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'h0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'h0, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    // Fires on the cycle that would make the wait TIMEOUT_CYCLES long.
    assign tmo_hit = (TIMEOUT_CYCLES != 0)
                   && ((tmo_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            addr_lo      <= '0;
            f3           <= '0;
            is_wr        <= 1'b0;
            core_rdata   <= '0;
            core_rvalid  <= 1'b0;
            misalign_exc <= 1'b0;
            bus_timeout  <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
        end else begin
            core_rvalid  <= 1'b0;
            bus_timeout  <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_lo <= core_addr[1:0];
                        f3      <= core_funct3;
                        is_wr   <= wr_sel;
                        tmo_cnt <= '0;
                        if (mis) begin
                            state        <= DONE;
                            misalign_exc <= 1'b1;
                            if (!wr_sel) begin
                                core_rvalid <= 1'b1;
                                core_rdata  <= '0;
                            end
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= wr_sel;
                            bus_addr  <= {core_addr[31:2], 2'b00};
                            bus_be    <= be_nxt;
                            bus_wdata <= wdata_nxt;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= is_wr ? DONE : WAIT_R;
                    end else if (tmo_hit) begin
                        bus_req     <= 1'b0;
                        bus_timeout <= 1'b1;
                        state       <= DONE;
                        if (!is_wr) begin
                            core_rvalid <= 1'b1;
                            core_rdata  <= RESP_ERR_DATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        core_rdata  <= rd_ext;
                        core_rvalid <= 1'b1;
                        state       <= DONE;
                    end else if (tmo_hit) begin
                        core_rdata  <= RESP_ERR_DATA;
                        core_rvalid <= 1'b1;
                        bus_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// tb_lsu_dmem_bridge: randomized scoreboard bench for lsu_dmem_bridge.
// A driver issues core accesses, a bus responder follows a per-access plan.
module tb_lsu_dmem_bridge;

    localparam int T = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        core_req_r, core_req_w;
    logic [31:0] core_addr, core_wdata;
    logic [2:0]  core_funct3;
    logic        core_stall, core_rvalid, misalign_exc, bus_timeout;
    logic [31:0] core_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        manual = 1'b0;
    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] r_rdata = 32'h0, m_rdata = 32'h0;

    assign bus_gnt    = manual ? m_gnt    : r_gnt;
    assign bus_rvalid = manual ? m_rvalid : r_rvalid;
    assign bus_rdata  = manual ? m_rdata  : r_rdata;

    always #5 CLK = ~CLK;

    lsu_dmem_bridge #(.TIMEOUT_CYCLES(T), .RESP_ERR_DATA(ERR)) dut (
        .CLK(CLK), .RESET(RESET),
        .core_req_r(core_req_r), .core_req_w(core_req_w),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_funct3(core_funct3), .core_stall(core_stall),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .misalign_exc(misalign_exc), .bus_timeout(bus_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        rvalid;
        logic [31:0] rdata;
        logic        tmo;
        logic        mis;
        int          lat;
    } done_exp_t;

    typedef struct {
        int          d;
        int          r;
        logic        rd;
        logic [31:0] rdata;
    } plan_t;

    bus_exp_t  bq[$];
    done_exp_t dq[$];
    plan_t     pq[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (16 * ((a % 4) / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        case (size_of(f3))
            1:       return 4'(1 << (a % 4));
            2:       return ((a % 4) >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return (d % 256) * 32'h01010101;
            2:       return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input bit wr, input bit both, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int d, input int r, input logic [31:0] rd);
        done_exp_t e;
        bus_exp_t  b;
        plan_t     p;
        bit        trap = 1'b0;
        int        k = 0;
`ifdef MISALIGN_TRAP_EN
        trap = misaligned(f3, a);
`endif
        e.rvalid = 1'b0; e.rdata = 32'h0; e.tmo = 1'b0; e.mis = trap; e.lat = 0;
        if (trap) begin
            e.lat = 2;
            e.rvalid = !wr;
        end else begin
            p.d = d; p.r = r; p.rd = !wr; p.rdata = rd;
            pq.push_back(p);
            if (d < T) begin
                b.we = wr; b.addr = a & ~32'd3;
                b.be = wr ? model_be(f3, a) : 4'hF;
                b.wdata = model_wdata(f3, wd);
                bq.push_back(b);
            end
            if (d >= T) begin
                e.tmo = 1'b1; e.lat = T + 2;
                if (!wr) begin e.rvalid = 1'b1; e.rdata = ERR; end
            end else if (wr) begin
                e.lat = d + 3;
            end else if (r >= T) begin
                e.tmo = 1'b1; e.lat = d + T + 3;
                e.rvalid = 1'b1; e.rdata = ERR;
            end else begin
                e.lat = d + r + 4;
                e.rvalid = 1'b1; e.rdata = model_load(f3, a, rd);
            end
        end
        dq.push_back(e);
        core_req_w = wr; core_req_r = !wr || both;
        core_addr = a; core_wdata = wd; core_funct3 = f3;
        forever begin
            @(negedge CLK);
            if (!core_stall) break;
            k++;
            if (k > 40) begin
                checks++; errors++;
                $display("FAIL stall_release: got stuck expected release");
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        core_req_r = 1'b0; core_req_w = 1'b0;
    endtask

    // ---------------- bus responder ----------------
    initial begin
        plan_t p;
        forever begin
            @(posedge CLK); #1;
            if (bus_req && !manual && !RESET) begin
                if (pq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unplanned_req: got bus_req expected none");
                    while (bus_req) begin @(posedge CLK); #1; end
                end else begin
                    p = pq.pop_front();
                    if (p.d < T) begin
                        for (int k = 0; k < p.d; k++) begin
                            r_rvalid = 1'($urandom_range(0, 1)); r_rdata = $urandom;
                            @(posedge CLK); #1;
                        end
                        r_gnt = 1'b1; r_rvalid = 1'($urandom_range(0, 1));
                        @(posedge CLK); #1;
                        r_gnt = 1'b0; r_rvalid = 1'b0;
                        if (p.rd && p.r < T) begin
                            repeat (p.r) begin @(posedge CLK); #1; end
                            r_rvalid = 1'b1; r_rdata = p.rdata;
                            @(posedge CLK); #1;
                            r_rvalid = 1'b0; r_rdata = $urandom;
                        end
                    end else begin
                        for (int k = 0; k < 100 && bus_req; k++) begin
                            r_rvalid = 1'($urandom_range(0, 1)); r_rdata = $urandom;
                            @(posedge CLK); #1;
                        end
                        r_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bus_exp_t  mb;
        done_exp_t md;
        int lat = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                lat = 0;
            end else begin
                if (core_req_r || core_req_w) lat++;
                if (bus_req && bus_gnt) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_accept: got accept expected none");
                    end else begin
                        mb = bq.pop_front();
                        check("bus_we", bus_we, mb.we);
                        check("bus_addr", bus_addr, mb.addr);
                        check("bus_be", bus_be, mb.be);
                        if (mb.we) check("bus_wdata", bus_wdata, mb.wdata);
                    end
                end
                if ((core_req_r || core_req_w) && !core_stall) begin
                    if (dq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done: got completion expected none");
                    end else begin
                        md = dq.pop_front();
                        check("core_rvalid", core_rvalid, md.rvalid);
                        check("bus_timeout", bus_timeout, md.tmo);
                        check("misalign_exc", misalign_exc, md.mis);
                        check("latency", lat, md.lat);
                        if (md.rvalid) check("core_rdata", core_rdata, md.rdata);
                    end
                    lat = 0;
                end else begin
                    check("stray_pulse", {core_rvalid, bus_timeout, misalign_exc}, 0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rdata"}, core_rdata, 0);
        check({tag, "_rvalid"}, core_rvalid, 0);
        check({tag, "_mis"}, misalign_exc, 0);
        check({tag, "_tmo"}, bus_timeout, 0);
        check({tag, "_req"}, bus_req, 0);
        check({tag, "_we"}, bus_we, 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_be"}, bus_be, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
        check({tag, "_stall"}, core_stall, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_exp_t b;
        bit wr;
        logic [2:0] f3;
        RESET = 1'b1;
        core_req_r = 1'b0; core_req_w = 1'b0;
        core_addr = 32'h0; core_wdata = 32'h0; core_funct3 = 3'h0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_zero("reset");
        @(posedge CLK); #1;

        issue(1, 0, 3'b010, 32'h100, 32'h12345678, 0, 0, 0);
        issue(0, 0, 3'b010, 32'h100, 0, 0, 0, 32'h12345678);
        issue(0, 0, 3'b000, 32'h203, 0, 0, 0, 32'h80FF7F01);
        issue(0, 0, 3'b100, 32'h203, 0, 0, 1, 32'h80FF7F01);
        issue(0, 0, 3'b000, 32'h200, 0, 1, 0, 32'h80FF7F01);
        issue(1, 0, 3'b000, 32'h301, 32'h000000AB, 0, 0, 0);
        issue(1, 0, 3'b001, 32'h302, 32'h0000BEEF, 0, 0, 0);
        issue(0, 0, 3'b010, 32'h400, 0, T + 5, 0, 0);
        issue(0, 0, 3'b010, 32'h102, 0, 0, 0, 32'hCAFEF00D);
        issue(0, 0, 3'b001, 32'h206, 0, 2, T + 5, 0);
        issue(1, 0, 3'b010, 32'h500, 32'h1, T + 5, 0, 0);
        issue(1, 1, 3'b001, 32'h501, 32'h7777, 3, 0, 0);
        issue(0, 0, 3'b101, 32'h502, 0, T - 1, T - 1, 32'h80017FFF);

        // Reset while a read waits for rvalid; rvalid then arrives in IDLE.
        manual = 1'b1;
        b.we = 1'b0; b.addr = 32'h200; b.be = 4'hF; b.wdata = 32'h0;
        bq.push_back(b);
        core_req_r = 1'b1; core_addr = 32'h200; core_funct3 = 3'b010;
        @(posedge CLK); #1;
        m_gnt = 1'b1;
        @(posedge CLK); #1;
        m_gnt = 1'b0; RESET = 1'b1; core_req_r = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55AA55AA;
        @(negedge CLK);
        check_zero("midrst");
        @(posedge CLK); #1;
        m_rvalid = 1'b0;
        @(negedge CLK);
        check_zero("late_rvalid");
        @(posedge CLK); #1;
        manual = 1'b0;

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            issue(wr, wr && $urandom_range(0, 3) == 0, f3, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end

        repeat (10) @(posedge CLK);
        check("bq_left", bq.size(), 0);
        check("dq_left", dq.size(), 0);
        check("pq_left", pq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
